// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register and ALU operand selection.
// Captures decoded operands and control from ID. Forwards EX/MEM and MEM/WB
// results into the operands and detects load-use hazards.
// Ports:
//   clk, reset                     clock, async active-high reset
//   id_*                           decoded instruction from ID
//   flush, ex_stall                squash / hold of the EX slot
//   mem_*, wb_*                    forwarding sources (EX/MEM, MEM/WB)
//   alu_in1, alu_in2, alu_ctrl     ALU operands and operation
//   ex_*                           registered control and destination
//   store_data                     forwarded rt value for stores
//   stall_if_id                    hold PC and IF/ID (combinational)
module id_ex_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_uses_rt,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic [2:0]        id_alu_ctrl,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              flush,
  input  logic              ex_stall,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_result,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [2:0]        alu_ctrl,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic [REG_AW-1:0] ex_dest,
  output logic [DATA_W-1:0] store_data,
  output logic              stall_if_id
);

  localparam int unsigned CTRL_W = 3;

  logic              r_valid;
  logic              r_reg_write;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_mem_to_reg;
  logic              r_alu_src;
  logic [CTRL_W-1:0] r_alu_ctrl;
  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic [REG_AW-1:0] r_dest;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;

  logic              w_load_use;
  logic              w_bubble;
  logic              w_mem_hit_rs;
  logic              w_mem_hit_rt;
  logic              w_wb_hit_rs;
  logic              w_wb_hit_rt;
  logic [DATA_W-1:0] w_fwd_a;
  logic [DATA_W-1:0] w_fwd_b;

  // Load in EX whose destination is read by the instruction in ID.
  assign w_load_use = r_valid && r_mem_read && (r_dest != '0) && id_valid &&
                      ((r_dest == id_rs) || (id_uses_rt && (r_dest == id_rt)));

  // A flush always squashes; a load-use bubble only when EX is not held.
  assign w_bubble = flush || (!ex_stall && w_load_use);

  // Forwarding hits; register $0 is never forwarded.
  assign w_mem_hit_rs = mem_reg_write && (mem_dest != '0) && (mem_dest == r_rs);
  assign w_mem_hit_rt = mem_reg_write && (mem_dest != '0) && (mem_dest == r_rt);
  assign w_wb_hit_rs  = wb_reg_write  && (wb_dest  != '0) && (wb_dest  == r_rs);
  assign w_wb_hit_rt  = wb_reg_write  && (wb_dest  != '0) && (wb_dest  == r_rt);

  // EX/MEM is newer than MEM/WB, so it wins.
  assign w_fwd_a = w_mem_hit_rs ? mem_result : (w_wb_hit_rs ? wb_result : r_rs_data);
  assign w_fwd_b = w_mem_hit_rt ? mem_result : (w_wb_hit_rt ? wb_result : r_rt_data);

  // EX slot register: bubble > hold > capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_alu_src    <= 1'b0;
      r_alu_ctrl   <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_dest       <= '0;
      r_rs_data    <= '0;
      r_rt_data    <= '0;
      r_imm        <= '0;
    end else if (w_bubble) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_alu_src    <= 1'b0;
      r_alu_ctrl   <= '0;
    end else if (ex_stall) begin
      // Values retiring from WB while held would otherwise be lost.
      if (w_wb_hit_rs) r_rs_data <= wb_result;
      if (w_wb_hit_rt) r_rt_data <= wb_result;
    end else begin
      r_valid      <= id_valid;
      r_reg_write  <= id_reg_write;
      r_mem_read   <= id_mem_read;
      r_mem_write  <= id_mem_write;
      r_mem_to_reg <= id_mem_to_reg;
      r_alu_src    <= id_alu_src;
      r_alu_ctrl   <= id_alu_ctrl;
      r_rs         <= id_rs;
      r_rt         <= id_rt;
      r_dest       <= id_reg_dst ? id_rd : id_rt;
      r_rs_data    <= id_rs_data;
      r_rt_data    <= id_rt_data;
      r_imm        <= id_imm;
    end
  end

  assign alu_in1       = w_fwd_a;
  assign alu_in2       = r_alu_src ? r_imm : w_fwd_b;
  assign alu_ctrl      = r_alu_ctrl;
  assign store_data    = w_fwd_b;
  assign ex_valid      = r_valid;
  assign ex_reg_write  = r_reg_write;
  assign ex_mem_read   = r_mem_read;
  assign ex_mem_write  = r_mem_write;
  assign ex_mem_to_reg = r_mem_to_reg;
  assign ex_dest       = r_dest;
  assign stall_if_id   = w_load_use || ex_stall;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed scenarios plus randomized traffic, checked every
// cycle against a behavioural model of the instruction sitting in EX.
module tb_id_ex_stage;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_uses_rt, id_alu_src, id_reg_dst;
  logic [2:0]  id_alu_ctrl;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        flush, ex_stall;
  logic        mem_reg_write;
  logic [4:0]  mem_dest;
  logic [31:0] mem_result;
  logic        wb_reg_write;
  logic [4:0]  wb_dest;
  logic [31:0] wb_result;
  logic [31:0] alu_in1, alu_in2, store_data;
  logic [2:0]  alu_ctrl;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic [4:0]  ex_dest;
  logic        stall_if_id;

  int n_checks = 0;
  int n_fail   = 0;

  id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_uses_rt(id_uses_rt), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
    .id_alu_ctrl(id_alu_ctrl), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .flush(flush), .ex_stall(ex_stall),
    .mem_reg_write(mem_reg_write), .mem_dest(mem_dest), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_dest(wb_dest), .wb_result(wb_result),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_dest(ex_dest), .store_data(store_data), .stall_if_id(stall_if_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the instruction occupying EX.
  logic        m_valid = 1'b0, m_rw = 1'b0, m_mr = 1'b0, m_mw = 1'b0, m_m2r = 1'b0;
  logic        m_alu_src = 1'b0;
  logic [2:0]  m_ctrl = 3'd0;
  logic [4:0]  m_rs = 5'd0, m_rt = 5'd0, m_dest = 5'd0;
  logic [31:0] m_rs_d = 32'd0, m_rt_d = 32'd0, m_imm = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Newest producer of register r, or the value read in ID.
  function automatic logic [31:0] newest(input logic [4:0] r, input logic [31:0] d);
    if (r != 5'd0 && mem_reg_write && mem_dest == r) return mem_result;
    if (r != 5'd0 && wb_reg_write && wb_dest == r) return wb_result;
    return d;
  endfunction

  function automatic logic hazard();
    return m_valid && m_mr && m_dest != 5'd0 && id_valid &&
           (m_dest == id_rs || (id_uses_rt && m_dest == id_rt));
  endfunction

  always @(posedge clk or posedge reset) begin
    logic lu;
    if (reset) begin
      m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_m2r = 0; m_alu_src = 0;
      m_ctrl = 0; m_rs = 0; m_rt = 0; m_dest = 0; m_rs_d = 0; m_rt_d = 0; m_imm = 0;
    end else begin
      lu = hazard();
      if (flush || (!ex_stall && lu)) begin
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_m2r = 0;
      end else if (ex_stall) begin
        if (wb_reg_write && wb_dest != 0 && wb_dest == m_rs) m_rs_d = wb_result;
        if (wb_reg_write && wb_dest != 0 && wb_dest == m_rt) m_rt_d = wb_result;
      end else begin
        m_valid = id_valid; m_rw = id_reg_write; m_mr = id_mem_read;
        m_mw = id_mem_write; m_m2r = id_mem_to_reg; m_alu_src = id_alu_src;
        m_ctrl = id_alu_ctrl; m_rs = id_rs; m_rt = id_rt;
        m_dest = id_reg_dst ? id_rd : id_rt;
        m_rs_d = id_rs_data; m_rt_d = id_rt_data; m_imm = id_imm;
      end
    end
  end

  // Compare process: inputs change at negedge, outputs checked 1 unit later.
  always @(negedge clk) begin
    #1;
    if (!reset) begin
      chk("stall_if_id", 32'(stall_if_id), 32'(hazard() || ex_stall));
      chk("ex_valid", 32'(ex_valid), 32'(m_valid));
      chk("ex_reg_write", 32'(ex_reg_write), 32'(m_rw));
      chk("ex_mem_read", 32'(ex_mem_read), 32'(m_mr));
      chk("ex_mem_write", 32'(ex_mem_write), 32'(m_mw));
      chk("ex_mem_to_reg", 32'(ex_mem_to_reg), 32'(m_m2r));
      if (m_valid) begin
        chk("alu_in1", alu_in1, newest(m_rs, m_rs_d));
        chk("alu_in2", alu_in2, m_alu_src ? m_imm : newest(m_rt, m_rt_d));
        chk("store_data", store_data, newest(m_rt, m_rt_d));
        chk("alu_ctrl", 32'(alu_ctrl), 32'(m_ctrl));
        chk("ex_dest", 32'(ex_dest), 32'(m_dest));
      end
    end
  end

  task automatic set_idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    id_uses_rt = 0; id_alu_src = 0; id_reg_dst = 0; id_alu_ctrl = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
    flush = 0; ex_stall = 0;
    mem_reg_write = 0; mem_dest = 0; mem_result = 0;
    wb_reg_write = 0; wb_dest = 0; wb_result = 0;
  endtask

  task automatic drive_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] rs_d, input logic [31:0] rt_d,
                          input logic [31:0] imm, input logic uses_rt, input logic alu_src,
                          input logic reg_dst, input logic [2:0] ctrl, input logic rw,
                          input logic mr, input logic mw, input logic m2r);
    set_idle();
    id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rs_d; id_rt_data = rt_d; id_imm = imm;
    id_uses_rt = uses_rt; id_alu_src = alu_src; id_reg_dst = reg_dst;
    id_alu_ctrl = ctrl; id_reg_write = rw; id_mem_read = mr;
    id_mem_write = mw; id_mem_to_reg = m2r;
  endtask

  initial begin
    reset = 1'b1;
    set_idle();
    repeat (2) @(negedge clk);
    #2;
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_alu_in1", alu_in1, 32'd0);
    chk("rst_ex_reg_write", 32'(ex_reg_write), 32'd0);
    reset = 1'b0;

    // Capture: add $3, $1, $2
    @(negedge clk); drive_id(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 1, 0, 1, 3'b010, 1, 0, 0, 0);
    @(negedge clk); set_idle(); #2;
    chk("cap_in1", alu_in1, 32'd5);
    chk("cap_in2", alu_in2, 32'd7);
    chk("cap_dest", 32'(ex_dest), 32'd3);
    chk("cap_reg_write", 32'(ex_reg_write), 32'd1);
    chk("cap_ctrl", 32'(alu_ctrl), 32'd2);
    chk("model_pin_in1", newest(m_rs, m_rs_d), 32'd5);

    // Forwarding priority on rs=4
    @(negedge clk); drive_id(5'd4, 5'd5, 5'd6, 32'h11, 32'h22, 32'd0, 1, 0, 1, 3'b010, 1, 0, 0, 0);
    @(negedge clk); set_idle();
    mem_reg_write = 1; mem_dest = 5'd4; mem_result = 32'hAA;
    wb_reg_write = 1; wb_dest = 5'd4; wb_result = 32'hBB;
    #2 chk("fwd_mem_wins", alu_in1, 32'hAA);
    chk("model_pin_fwd", newest(m_rs, m_rs_d), 32'hAA);
    mem_reg_write = 0;
    #1 chk("fwd_wb", alu_in1, 32'hBB);

    // $0 never forwarded
    @(negedge clk); drive_id(5'd0, 5'd5, 5'd6, 32'h33, 32'h0, 32'd0, 1, 0, 1, 3'b000, 1, 0, 0, 0);
    @(negedge clk); set_idle(); mem_reg_write = 1; mem_dest = 5'd0; mem_result = 32'hFF;
    #2 chk("zero_guard", alu_in1, 32'h33);

    // Load-use: lw $8, 4($1) followed by add $9, $8, $2
    @(negedge clk); drive_id(5'd1, 5'd8, 5'd0, 32'h100, 32'h0, 32'd4, 0, 1, 0, 3'b010, 1, 1, 0, 1);
    @(negedge clk); drive_id(5'd8, 5'd2, 5'd9, 32'h0, 32'd3, 32'd0, 1, 0, 1, 3'b010, 1, 0, 0, 0);
    #2 chk("lu_stall", 32'(stall_if_id), 32'd1);
    @(negedge clk); #2;
    chk("lu_bubble", 32'(ex_valid), 32'd0);
    chk("lu_stall_clear", 32'(stall_if_id), 32'd0);
    @(negedge clk); set_idle(); wb_reg_write = 1; wb_dest = 5'd8; wb_result = 32'h77;
    #2;
    chk("lu_add_valid", 32'(ex_valid), 32'd1);
    chk("lu_add_fwd", alu_in1, 32'h77);
    chk("lu_add_in2", alu_in2, 32'd3);
    chk("lu_add_dest", 32'(ex_dest), 32'd9);

    // Stall with WB retire of held rt=9
    @(negedge clk); drive_id(5'd1, 5'd9, 5'd0, 32'h200, 32'h1, 32'd8, 1, 1, 0, 3'b010, 0, 0, 1, 0);
    @(negedge clk); set_idle(); ex_stall = 1; wb_reg_write = 1; wb_dest = 5'd9; wb_result = 32'h1234;
    #2 chk("stall_out", 32'(stall_if_id), 32'd1);
    @(negedge clk); set_idle(); ex_stall = 1;
    @(negedge clk); set_idle(); #2;
    chk("stall_store_data", store_data, 32'h1234);
    chk("stall_in2_imm", alu_in2, 32'd8);
    chk("stall_mem_write", 32'(ex_mem_write), 32'd1);

    // Flush beats a valid ID instruction
    @(negedge clk); drive_id(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 1, 0, 1, 3'b010, 1, 0, 0, 0);
    flush = 1;
    @(negedge clk); set_idle(); #2;
    chk("flush_valid", 32'(ex_valid), 32'd0);
    chk("flush_reg_write", 32'(ex_reg_write), 32'd0);

    // Async reset mid-cycle while stalled
    @(negedge clk); drive_id(5'd3, 5'd4, 5'd0, 32'h99, 32'h5, 32'd12, 1, 1, 0, 3'b010, 1, 1, 0, 1);
    @(negedge clk); set_idle(); ex_stall = 1; #2;
    chk("pre_rst_valid", 32'(ex_valid), 32'd1);
    reset = 1;
    #1;
    chk("arst_valid", 32'(ex_valid), 32'd0);
    chk("arst_mem_read", 32'(ex_mem_read), 32'd0);
    chk("arst_reg_write", 32'(ex_reg_write), 32'd0);
    chk("arst_in1", alu_in1, 32'd0);
    chk("arst_in2", alu_in2, 32'd0);
    chk("arst_store", store_data, 32'd0);
    chk("arst_dest", 32'(ex_dest), 32'd0);
    chk("arst_stall_in", 32'(stall_if_id), 32'd1);
    ex_stall = 0;
    #1 reset = 0;

    // Randomized traffic; small register range to provoke collisions
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      id_valid = ($urandom_range(0, 3) != 0);
      id_rs = 5'($urandom_range(0, 7)); id_rt = 5'($urandom_range(0, 7));
      id_rd = 5'($urandom_range(0, 7));
      id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
      id_uses_rt = 1'($urandom_range(0, 1)); id_alu_src = 1'($urandom_range(0, 1));
      id_reg_dst = 1'($urandom_range(0, 1)); id_alu_ctrl = 3'($urandom_range(0, 7));
      id_reg_write = 1'($urandom_range(0, 1)); id_mem_read = ($urandom_range(0, 2) == 0);
      id_mem_write = 1'($urandom_range(0, 1)); id_mem_to_reg = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 15) == 0);
      ex_stall = ($urandom_range(0, 4) == 0);
      mem_reg_write = 1'($urandom_range(0, 1)); mem_dest = 5'($urandom_range(0, 7));
      mem_result = $urandom;
      wb_reg_write = 1'($urandom_range(0, 1)); wb_dest = 5'($urandom_range(0, 7));
      wb_result = $urandom;
    end
    @(negedge clk); set_idle();
    repeat (2) @(negedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
